// File: rtl/muldiv_pkg.sv
// Shared types and elaboration helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  // Number of RUN cycles for an operation.
  function automatic int unsigned md_iters(input int unsigned width, input int unsigned unroll);
    return width / unroll;
  endfunction

  // Legal WIDTH/UNROLL combination: even width >= 4, unroll divides width.
  function automatic bit md_cfg_ok(input int unsigned width, input int unsigned unroll);
    return (width >= 4) && ((width % 2) == 0) && (unroll != 0) && ((width % unroll) == 0);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Controller <-> multiply/divide unit signal bundle.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_we;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mt_we, mt_sel, mt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mt_we, mt_sel, mt_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step.
// Multiply: {hi,lo} = accumulator:multiplier, m = multiplicand.
// Divide:   hi = partial remainder, lo = dividend/quotient, m = divisor.
module md_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;

  // Conditional add then right shift, or trial subtract with restore then left shift.
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m} : '0);
    shl  = {hi_i, lo_i[WIDTH-1]};
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
    if (is_div) begin
      if (shl >= {1'b0, m}) begin
        hi_o = WIDTH'(shl - {1'b0, m});
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shl[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned N     = md_iters(WIDTH, UNROLL);
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!md_cfg_ok(WIDTH, UNROLL)) begin : g_cfg_check
    $error("muldiv_unit: unsupported WIDTH/UNROLL combination");
  end

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   wh_q, wh_d;
  logic [WIDTH-1:0]   wl_q, wl_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed;
  logic               op_div;
  logic               div_zero;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   chain_hi [UNROLL+1];
  logic [WIDTH-1:0]   chain_lo [UNROLL+1];

  assign chain_hi[0] = wh_q;
  assign chain_lo[0] = wl_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    md_step #(.WIDTH(WIDTH)) u_step (
      .is_div (div_q),
      .m      (m_q),
      .hi_i   (chain_hi[i]),
      .lo_i   (chain_lo[i]),
      .hi_o   (chain_hi[i+1]),
      .lo_o   (chain_lo[i+1])
    );
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state: operand capture, iteration, sign fix-up and HI/LO writes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    wh_d      = wh_q;
    wl_d      = wl_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    div_d     = div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    op_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    op_div    = bus.op[1];
    div_zero  = op_div && (bus.b == '0);
    // Divide-by-zero keeps raw a so the remainder path shifts it back out unchanged.
    a_neg     = op_signed && bus.a[WIDTH-1] && !div_zero;
    b_neg     = op_signed && bus.b[WIDTH-1] && !div_zero;
    abs_a     = a_neg ? WIDTH'(-bus.a) : bus.a;
    abs_b     = b_neg ? WIDTH'(-bus.b) : bus.b;
    prod      = {wh_q, wl_q};

    case (state_q)
      IDLE: begin
        if (bus.mt_we) begin
          if (bus.mt_sel) hi_d = bus.mt_data;
          else            lo_d = bus.mt_data;
        end
        if (bus.start) begin
          m_d     = op_div ? abs_b : abs_a;
          wl_d    = op_div ? abs_a : abs_b;
          wh_d    = '0;
          sa_d    = a_neg;
          sb_d    = b_neg;
          div_d   = op_div;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        wh_d  = chain_hi[UNROLL];
        wl_d  = chain_lo[UNROLL];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          lo_d = (sa_q ^ sb_q) ? WIDTH'(-wl_q) : wl_q;
          hi_d = sa_q ? WIDTH'(-wh_q) : wh_q;
        end else begin
          if (sa_q ^ sb_q) prod = (2*WIDTH)'(-prod);
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: UNROLL=1 and UNROLL=4 units against an arithmetic reference.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   fails;

  muldiv_unit_if #(.WIDTH(32)) bus1 ();
  muldiv_unit_if #(.WIDTH(32)) bus4 ();

  muldiv_unit #(.WIDTH(32), .UNROLL(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  muldiv_unit #(.WIDTH(32), .UNROLL(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result as {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    int     ia;
    int     ib;
    logic [63:0] r;
    r = '0;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        r  = p;
      end
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          ia = a;
          ib = b;
          r  = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue the same op to both units and check latency, busy span and result.
  task automatic run_both(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int k1, k4, bc1, bc4;
    logic [63:0] r1, r4, exp;
    k1 = -1; k4 = -1; bc1 = 0; bc4 = 0; r1 = '0; r4 = '0;
    exp = ref_md(op, a, b);
    bus1.op = md_op_t'(op); bus1.a = a; bus1.b = b; bus1.start = 1'b1;
    bus4.op = md_op_t'(op); bus4.a = a; bus4.b = b; bus4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (bus1.busy) bc1++;
      if (bus4.busy) bc4++;
      if (bus1.done && k1 < 0) begin k1 = k; r1 = {bus1.hi, bus1.lo}; end
      if (bus4.done && k4 < 0) begin k4 = k; r4 = {bus4.hi, bus4.lo}; end
      if (k1 >= 0 && k4 >= 0) break;
      @(negedge clk);
    end
    check($sformatf("lat_u1 op%0d", op), 64'(k1), 64'd33);
    check($sformatf("lat_u4 op%0d", op), 64'(k4), 64'd9);
    check($sformatf("busy_u1 op%0d", op), 64'(bc1), 64'd33);
    check($sformatf("busy_u4 op%0d", op), 64'(bc4), 64'd9);
    check($sformatf("res_u1 op%0d a=%0h b=%0h", op, a, b), r1, exp);
    check($sformatf("res_u4 op%0d a=%0h b=%0h", op, a, b), r4, exp);
  endtask

  // Start an op on unit 1 only; returns at the negedge after the accepting edge.
  task automatic issue1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus1.op = md_op_t'(op); bus1.a = a; bus1.b = b; bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic wait_done1(output int k, output logic [63:0] r);
    k = -1;
    r = '0;
    for (int kk = 0; kk <= 40; kk++) begin
      if (bus1.done) begin k = kk; r = {bus1.hi, bus1.lo}; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int          k;
    logic [63:0] r;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    total = 0; passed = 0; fails = 0;
    reset = 1'b1;
    bus1.start = 1'b0; bus1.op = MD_MULT; bus1.a = '0; bus1.b = '0;
    bus1.mt_we = 1'b0; bus1.mt_sel = 1'b0; bus1.mt_data = '0;
    bus4.start = 1'b0; bus4.op = MD_MULT; bus4.a = '0; bus4.b = '0;
    bus4.mt_we = 1'b0; bus4.mt_sel = 1'b0; bus4.mt_data = '0;
    repeat (2) @(negedge clk);
    check("reset_u1", {31'd0, bus1.busy, bus1.done, bus1.hi, bus1.lo}, 64'd0);
    check("reset_u4", {31'd0, bus4.busy, bus4.done, bus4.hi, bus4.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_both(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_both(2'b00, 32'hFFFF_FFF9, 32'd3);
    run_both(2'b00, 32'h8000_0000, 32'h8000_0000);
    run_both(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_both(2'b11, 32'd7, 32'd2);
    run_both(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_both(2'b11, 32'd5, 32'd0);
    run_both(2'b10, 32'hFFFF_FFFB, 32'd0);

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rnd_operand();
      rb  = rnd_operand();
      run_both(rop, ra, rb);
    end

    // start and mt_we during RUN are ignored.
    issue1(2'b01, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    bus1.start = 1'b1; bus1.op = MD_DIVU; bus1.a = 32'd1; bus1.b = 32'd1;
    bus1.mt_we = 1'b1; bus1.mt_sel = 1'b0; bus1.mt_data = 32'hDEAD;
    @(negedge clk);
    bus1.start = 1'b0; bus1.mt_we = 1'b0;
    wait_done1(k, r);
    check("midrun_lat", 64'(k), 64'd27);
    check("midrun_res", r, 64'd42);

    // Back-to-back start in the done cycle.
    issue1(2'b11, 32'd7, 32'd2);
    wait_done1(k, r);
    check("b2b_lat", 64'(k), 64'd33);
    check("b2b_res", r, {32'd1, 32'd3});

    // mthi / mtlo in IDLE.
    bus1.mt_we = 1'b1; bus1.mt_sel = 1'b1; bus1.mt_data = 32'h1234;
    @(negedge clk);
    bus1.mt_we = 1'b0;
    check("mthi", {bus1.hi, bus1.lo}, {32'h1234, 32'd3});
    bus1.mt_we = 1'b1; bus1.mt_sel = 1'b0; bus1.mt_data = 32'h5678;
    @(negedge clk);
    bus1.mt_we = 1'b0;
    check("mtlo", {bus1.hi, bus1.lo}, {32'h1234, 32'h5678});

    // mt_we together with an accepted start: write lands, then result overwrites.
    bus1.mt_we = 1'b1; bus1.mt_sel = 1'b1; bus1.mt_data = 32'hABCD;
    issue1(2'b01, 32'd3, 32'd5);
    bus1.mt_we = 1'b0;
    check("mt_with_start_hi", {31'd0, bus1.busy, bus1.hi}, {31'd0, 1'b1, 32'hABCD});
    wait_done1(k, r);
    check("mt_with_start_lat", 64'(k), 64'd33);
    check("mt_with_start_res", r, 64'd15);

    // Asynchronous reset in the middle of RUN.
    issue1(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_u1", {31'd0, bus1.busy, bus1.done, bus1.hi, bus1.lo}, 64'd0);
    check("midreset_u4", {31'd0, bus4.busy, bus4.done, bus4.hi, bus4.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_both(2'b01, 32'd6, 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
